sg_elem_reader: RTL and testbench
=================================

SG_ELEM_READER -- requirements
Module: sg_elem_reader

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 128, inbound data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter C_FIFO_DEPTH, default 16, element FIFO entries; a power of two, at least 4.
REQ-003 SHALL have localparam C_DATA_WORD_WIDTH = clog2(C_DATA_WIDTH/32+1), the word-enable width.
REQ-004 SHALL have port CLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port SG_DATA  in  C_DATA_WIDTH  inbound scatter-gather list data; word 0 at bits [31:0].
REQ-007 SHALL have port SG_DATA_EN  in  C_DATA_WORD_WIDTH  count of valid 32-bit words in SG_DATA, packed from word 0 upward.
REQ-008 SHALL have port SG_DONE  in  1  list-complete pulse.
REQ-009 SHALL have port SG_ERR  in  1  list-aborted-with-error pulse.
REQ-010 SHALL have port SG_ELEM_ADDR  out  64  head element address.
REQ-011 SHALL have port SG_ELEM_LEN  out  32  head element length, in 32-bit words.
REQ-012 SHALL have port SG_ELEM_RDY  out  1  head element valid.
REQ-013 SHALL have port SG_ELEM_REN  in  1  pop the head element.
REQ-014 SHALL have port SG_ELEM_COUNT  out  clog2(C_FIFO_DEPTH+1)  elements stored.
REQ-015 SHALL have port SG_LIST_DONE  out  1  one-cycle pulse: list finished.
REQ-016 SHALL have port SG_OVERFLOW  out  1  sticky: an element was dropped.

Function
REQ-017 SHALL treat the inbound word stream as 4-word elements: word0 = ADDR[31:0], word1 = ADDR[63:32], word2 = LEN, word3 = reserved and ignored.
REQ-018 SHALL keep a 2-bit element word position, advanced by the SG_DATA_EN count modulo 4 each beat, wrapping 3 -> 0.
REQ-019 SHALL clamp an SG_DATA_EN value above C_DATA_WIDTH/32 to C_DATA_WIDTH/32.
REQ-020 SHALL treat an element as complete on the beat that supplies its word3; at most one element completes per beat for every legal width.
REQ-021 SHALL register inbound beats in one input stage; for a beat completing an element sampled at edge N into an empty FIFO, SG_ELEM_RDY SHALL be high after edge N+2.
REQ-022 SHALL implement the FIFO as show-ahead: ADDR and LEN are valid whenever RDY is 1.
REQ-023 SHALL pop the head element on REN=1 with RDY=1; REN with RDY=0 SHALL be ignored.
REQ-024 SHALL, on a simultaneous push and pop, leave SG_ELEM_COUNT unchanged; this includes the case where the FIFO is full.
REQ-025 SHALL, when an element completes with the FIFO full and no pop in that cycle, drop that element and set SG_OVERFLOW until RST.
REQ-026 SHALL, for SG_DONE in the same beat as SG_DATA_EN, process the beat's words first.
REQ-027 SHALL, on SG_DONE, then discard any partial element, clear the word position, and pulse SG_LIST_DONE in the same cycle the final element is written.
REQ-028 SHALL, on SG_ERR, discard any partial element, flush the FIFO (COUNT becomes 0, RDY becomes 0), clear the word position, and not pulse SG_LIST_DONE.
REQ-029 SHALL, if SG_ERR and SG_DONE are both high, apply the SG_ERR behaviour only.
REQ-030 SHALL implement an assembler FSM with states IDLE (position 0, no partial element) and FILL (partial element held); DONE or ERR SHALL return it to IDLE.

Reset
REQ-031 SHALL, on RST, give SG_ELEM_RDY=0, SG_ELEM_COUNT=0, SG_LIST_DONE=0, SG_OVERFLOW=0, SG_ELEM_ADDR=0, SG_ELEM_LEN=0, word position 0, FSM IDLE, input stage cleared.
REQ-032 SHALL, on RST asserted mid-list, lose all stored and partial elements with no output pulse.
REQ-033 SHALL ignore inputs during the reset cycle.

Configuration
REQ-034 SHALL, with SG_ELEM_SKIP_ZERO_LEN_EN defined, not write completed elements with LEN=0 to the FIFO and not count them toward overflow.
REQ-035 SHALL, without SG_ELEM_SKIP_ZERO_LEN_EN, write zero-length elements like any other element.

Verification
REQ-036 The bench SHALL cover: C_DATA_WIDTH=128, one beat EN=4, words {0x1000, 0x0, 0x80, 0x0} -> RDY high 2 cycles later, ADDR=0x1000, LEN=0x80, COUNT=1.
REQ-037 The bench SHALL cover: C_DATA_WIDTH=128, beats EN=3, EN=4, EN=1 carrying 2 elements {A=0x2000_0000_0000_0010, LEN 4} and {A=0x30, LEN 8} -> 2 elements popped in order with correct values.
REQ-038 The bench SHALL cover: C_FIFO_DEPTH=4, 5 elements with REN=0 -> COUNT=4, SG_OVERFLOW=1, the first 4 elements intact.
REQ-039 The bench SHALL cover: 6 words then SG_DONE -> 1 element stored, partial discarded, SG_LIST_DONE one pulse, next list starts at word0.
REQ-040 The bench SHALL cover: 3 elements stored, then SG_ERR together with SG_DONE -> COUNT=0, RDY=0, no LIST_DONE pulse.
REQ-041 The bench SHALL cover: the element LEN=0 sent with and without SG_ELEM_SKIP_ZERO_LEN_EN -> COUNT 0 and 1 respectively; C_DATA_WIDTH=32 with EN=1 per beat -> same results as 128.

Source files
------------

// File: rtl/sg_elem_reader.sv
// Scatter-gather element reader: assembles 4-word {addr_lo, addr_hi, len, rsvd} elements
// from a packed word stream into a show-ahead FIFO. Optional macro: SG_ELEM_SKIP_ZERO_LEN_EN.
`timescale 1ns/1ps
module sg_elem_reader #(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_FIFO_DEPTH = 16,
    localparam int C_DATA_WORD_WIDTH = $clog2(C_DATA_WIDTH/32 + 1),
    localparam int C_COUNT_WIDTH = $clog2(C_FIFO_DEPTH + 1)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [C_DATA_WIDTH-1:0]      SG_DATA,
    input  logic [C_DATA_WORD_WIDTH-1:0] SG_DATA_EN,
    input  logic                         SG_DONE,
    input  logic                         SG_ERR,
    output logic [63:0]                  SG_ELEM_ADDR,
    output logic [31:0]                  SG_ELEM_LEN,
    output logic                         SG_ELEM_RDY,
    input  logic                         SG_ELEM_REN,
    output logic [C_COUNT_WIDTH-1:0]     SG_ELEM_COUNT,
    output logic                         SG_LIST_DONE,
    output logic                         SG_OVERFLOW
);
    localparam int C_WORDS     = C_DATA_WIDTH / 32;
    localparam int C_PTR_WIDTH = $clog2(C_FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_FILL} asm_state_t;

    // Input stage
    logic [C_DATA_WIDTH-1:0]      in_data_reg;
    logic [C_DATA_WORD_WIDTH-1:0] in_en_reg;
    logic                         in_done_reg;
    logic                         in_err_reg;
    logic [C_DATA_WORD_WIDTH-1:0] en_clamped;

    assign en_clamped = (SG_DATA_EN > C_DATA_WORD_WIDTH'(C_WORDS)) ?
                        C_DATA_WORD_WIDTH'(C_WORDS) : SG_DATA_EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_data_reg <= '0;
            in_en_reg   <= '0;
            in_done_reg <= 1'b0;
            in_err_reg  <= 1'b0;
        end else begin
            in_data_reg <= SG_DATA;
            in_en_reg   <= en_clamped;
            in_done_reg <= SG_DONE;
            in_err_reg  <= SG_ERR;
        end
    end

    logic [31:0] beat_word [C_WORDS];

    generate
        for (genvar gi = 0; gi < C_WORDS; gi++) begin : g_word
            assign beat_word[gi] = in_data_reg[gi*32 +: 32];
        end
    endgenerate

    // Assembler
    asm_state_t  state_reg;
    logic [1:0]  pos_reg;
    logic [31:0] addr_lo_reg, addr_hi_reg, len_reg;
    logic [1:0]  base_pos, slot, pos_next;
    logic [31:0] addr_lo_next, addr_hi_next, len_next;
    logic        cpl;
    logic [63:0] cpl_addr;
    logic [31:0] cpl_len;
    logic        push_ok;

    // Words are applied in stream order, so a word3 snapshots the element built so far
    // and any later words in the same beat start the next element.
    always_comb begin
        base_pos     = (state_reg == ST_FILL) ? pos_reg : 2'd0;
        addr_lo_next = addr_lo_reg;
        addr_hi_next = addr_hi_reg;
        len_next     = len_reg;
        cpl          = 1'b0;
        cpl_addr     = '0;
        cpl_len      = '0;
        slot         = base_pos;
        for (int i = 0; i < C_WORDS; i++) begin
            slot = base_pos + 2'(i);
            if (i < int'(in_en_reg)) begin
                case (slot)
                    2'd0:    addr_lo_next = beat_word[i];
                    2'd1:    addr_hi_next = beat_word[i];
                    2'd2:    len_next     = beat_word[i];
                    default: begin
                        cpl      = 1'b1;
                        cpl_addr = {addr_hi_next, addr_lo_next};
                        cpl_len  = len_next;
                    end
                endcase
            end
        end
        pos_next = base_pos + 2'(in_en_reg);
    end

`ifdef SG_ELEM_SKIP_ZERO_LEN_EN
    assign push_ok = cpl && (cpl_len != 32'd0);
`else
    assign push_ok = cpl;
`endif

    logic        push_reg;
    logic [63:0] push_addr_reg;
    logic [31:0] push_len_reg;
    logic        done_stage_reg;
    logic        flush_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            pos_reg        <= 2'd0;
            addr_lo_reg    <= '0;
            addr_hi_reg    <= '0;
            len_reg        <= '0;
            push_reg       <= 1'b0;
            push_addr_reg  <= '0;
            push_len_reg   <= '0;
            done_stage_reg <= 1'b0;
            flush_reg      <= 1'b0;
        end else begin
            flush_reg      <= in_err_reg;
            done_stage_reg <= in_done_reg && !in_err_reg;
            if (in_err_reg) begin
                state_reg <= ST_IDLE;
                pos_reg   <= 2'd0;
                push_reg  <= 1'b0;
            end else begin
                push_reg      <= push_ok;
                push_addr_reg <= cpl_addr;
                push_len_reg  <= cpl_len;
                addr_lo_reg   <= addr_lo_next;
                addr_hi_reg   <= addr_hi_next;
                len_reg       <= len_next;
                if (in_done_reg || pos_next == 2'd0) begin
                    state_reg <= ST_IDLE;
                    pos_reg   <= 2'd0;
                end else begin
                    state_reg <= ST_FILL;
                    pos_reg   <= pos_next;
                end
            end
        end
    end

    // Element FIFO
    logic [95:0]              mem [C_FIFO_DEPTH];
    logic [95:0]              head_reg;
    logic [C_PTR_WIDTH-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [C_COUNT_WIDTH-1:0] count_reg;
    logic                     overflow_reg;
    logic                     list_done_reg;
    logic                     pop, wr_ok;

    always_comb begin
        pop         = SG_ELEM_REN && (count_reg != '0) && !flush_reg;
        wr_ok       = push_reg && !flush_reg &&
                      ((count_reg != C_COUNT_WIDTH'(C_FIFO_DEPTH)) || pop);
        rd_ptr_next = pop ? rd_ptr_reg + C_PTR_WIDTH'(1) : rd_ptr_reg;
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= {push_addr_reg, push_len_reg};
        end
    end

    // The head register only reloads on a pop or a write into an empty FIFO; a write
    // landing on the slot about to become head is forwarded directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            head_reg      <= '0;
            overflow_reg  <= 1'b0;
            list_done_reg <= 1'b0;
        end else begin
            list_done_reg <= done_stage_reg;
            if (push_reg && !wr_ok && !flush_reg) begin
                overflow_reg <= 1'b1;
            end
            if (flush_reg) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + C_PTR_WIDTH'(1);
                end
                rd_ptr_reg <= rd_ptr_next;
                count_reg  <= count_reg + C_COUNT_WIDTH'(wr_ok) - C_COUNT_WIDTH'(pop);
                if (pop || (wr_ok && count_reg == '0)) begin
                    head_reg <= (wr_ok && wr_ptr_reg == rd_ptr_next) ?
                                {push_addr_reg, push_len_reg} : mem[rd_ptr_next];
                end
            end
        end
    end

    assign SG_ELEM_ADDR  = head_reg[95:32];
    assign SG_ELEM_LEN   = head_reg[31:0];
    assign SG_ELEM_RDY   = (count_reg != '0);
    assign SG_ELEM_COUNT = count_reg;
    assign SG_LIST_DONE  = list_done_reg;
    assign SG_OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_sg_elem_reader.sv
// Directed scoreboard bench for sg_elem_reader: a 128-bit and a 32-bit instance (depth 4)
// run the same step sequence; sel picks the instance being driven and observed.
`timescale 1ns/1ps
module tb_sg_elem_reader;
`ifdef SG_ELEM_SKIP_ZERO_LEN_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic clk, rst, ren;
    int   sel;

    logic [127:0] w_data;
    logic [2:0]   w_en, w_cnt;
    logic         w_done, w_err, w_ren, w_rdy, w_ld, w_ovf;
    logic [63:0]  w_addr;
    logic [31:0]  w_len;

    logic [31:0]  n_data;
    logic         n_en;
    logic [2:0]   n_cnt;
    logic         n_done, n_err, n_ren, n_rdy, n_ld, n_ovf;
    logic [63:0]  n_addr;
    logic [31:0]  n_len;

    logic [63:0]  o_addr;
    logic [31:0]  o_len;
    logic [2:0]   o_cnt;
    logic         o_rdy, o_ld, o_ovf;

    assign w_ren  = ren && (sel == 0);
    assign n_ren  = ren && (sel == 1);
    assign o_addr = (sel == 0) ? w_addr : n_addr;
    assign o_len  = (sel == 0) ? w_len  : n_len;
    assign o_cnt  = (sel == 0) ? w_cnt  : n_cnt;
    assign o_rdy  = (sel == 0) ? w_rdy  : n_rdy;
    assign o_ld   = (sel == 0) ? w_ld   : n_ld;
    assign o_ovf  = (sel == 0) ? w_ovf  : n_ovf;

    sg_elem_reader #(.C_DATA_WIDTH(128), .C_FIFO_DEPTH(4)) u_dut_w128 (
        .CLK(clk), .RST(rst), .SG_DATA(w_data), .SG_DATA_EN(w_en),
        .SG_DONE(w_done), .SG_ERR(w_err), .SG_ELEM_ADDR(w_addr), .SG_ELEM_LEN(w_len),
        .SG_ELEM_RDY(w_rdy), .SG_ELEM_REN(w_ren), .SG_ELEM_COUNT(w_cnt),
        .SG_LIST_DONE(w_ld), .SG_OVERFLOW(w_ovf)
    );

    sg_elem_reader #(.C_DATA_WIDTH(32), .C_FIFO_DEPTH(4)) u_dut_w32 (
        .CLK(clk), .RST(rst), .SG_DATA(n_data), .SG_DATA_EN(n_en),
        .SG_DONE(n_done), .SG_ERR(n_err), .SG_ELEM_ADDR(n_addr), .SG_ELEM_LEN(n_len),
        .SG_ELEM_RDY(n_rdy), .SG_ELEM_REN(n_ren), .SG_ELEM_COUNT(n_cnt),
        .SG_LIST_DONE(n_ld), .SG_OVERFLOW(n_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] tx_words [$];
    int          tx_sizes [$];
    logic [63:0] sb_addr [$];
    logic [31:0] sb_len [$];
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s (dut %0d): observed 0x%0h expected 0x%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic beat(input logic [127:0] d, input logic [2:0] en,
                        input logic done, input logic err);
        if (sel == 0) begin
            w_data = d; w_en = en; w_done = done; w_err = err;
        end else begin
            n_data = d[31:0]; n_en = en[0]; n_done = done; n_err = err;
        end
        @(negedge clk);
        w_en = '0; w_done = 1'b0; w_err = 1'b0;
        n_en = 1'b0; n_done = 1'b0; n_err = 1'b0;
    endtask

    // 128-bit instance packs words by tx_sizes; 32-bit instance sends one word per beat.
    task automatic send(input logic done_last);
        int idx;
        int nsz;
        logic [127:0] d;
        idx = 0;
        if (sel == 0) begin
            for (int b = 0; b < tx_sizes.size(); b++) begin
                nsz = tx_sizes[b];
                d = '0;
                for (int j = 0; j < nsz; j++) d[j*32 +: 32] = tx_words[idx + j];
                idx += nsz;
                beat(d, 3'(nsz), done_last && (b == tx_sizes.size() - 1), 1'b0);
            end
        end else begin
            for (int i = 0; i < tx_words.size(); i++)
                beat({96'b0, tx_words[i]}, 3'd1, done_last && (i == tx_words.size() - 1), 1'b0);
        end
        tx_words.delete();
        tx_sizes.delete();
    endtask

    task automatic add_elem(input logic [63:0] a, input logic [31:0] l, input logic store);
        tx_words.push_back(a[31:0]);
        tx_words.push_back(a[63:32]);
        tx_words.push_back(l);
        tx_words.push_back(32'hDEAD_0000 | {16'h0, a[15:0]});
        tx_sizes.push_back(4);
        if (store) begin
            sb_addr.push_back(a);
            sb_len.push_back(l);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] ea;
        logic [31:0] el;
        chk($sformatf("%s_rdy", tag), o_rdy, 1);
        chk($sformatf("%s_sb_nonempty", tag), sb_addr.size() != 0, 1);
        if (sb_addr.size() != 0) begin
            ea = sb_addr.pop_front();
            el = sb_len.pop_front();
            chk($sformatf("%s_addr", tag), o_addr, ea);
            chk($sformatf("%s_len", tag), o_len, el);
        end
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb_addr.size() != 0) pop_chk(tag);
        chk($sformatf("%s_cnt_empty", tag), o_cnt, 0);
    endtask

    // Reset while presenting a complete element: the reset cycle must ignore it.
    task automatic do_reset();
        rst = 1'b1;
        w_data = {32'h0, 32'h77, 32'h0, 32'h770};
        w_en = 3'd4;
        n_data = 32'h770;
        n_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        w_en = '0;
        n_en = 1'b0;
        sb_addr.delete();
        sb_len.delete();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; sel = 0; ren = 1'b0; rst = 1'b0;
        w_data = '0; w_en = '0; w_done = 1'b0; w_err = 1'b0;
        n_data = '0; n_en = 1'b0; n_done = 1'b0; n_err = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
            cyc(3);
            chk("rst_rdy", o_rdy, 0);
            chk("rst_cnt", o_cnt, 0);
            chk("rst_ld", o_ld, 0);
            chk("rst_ovf", o_ovf, 0);
            chk("rst_addr", o_addr, 0);
            chk("rst_len", o_len, 0);

            // Single element, latency to RDY is two edges after the completing beat
            tx_words = '{32'h1000, 32'h0, 32'h80, 32'h0};
            tx_sizes.push_back(4);
            sb_addr.push_back(64'h1000);
            sb_len.push_back(32'h80);
            send(1'b0);
            cyc(1);
            chk("lat_rdy_n1", o_rdy, 0);
            cyc(1);
            chk("lat_rdy_n2", o_rdy, 1);
            chk("lat_cnt", o_cnt, 1);
            pop_chk("lat_pop");
            chk("lat_cnt_after_pop", o_cnt, 0);

            // EN above the bus word count is clamped
            if (sel == 0) begin
                sb_addr.push_back(64'h900);
                sb_len.push_back(32'h9);
                beat({32'h0, 32'h9, 32'h0, 32'h900}, 3'd7, 1'b0, 1'b0);
                cyc(3);
                chk("clamp_cnt", o_cnt, 1);
                drain("clamp");
            end

            // Two elements split across uneven beats
            add_elem(64'h2000_0000_0000_0010, 32'd4, 1'b1);
            add_elem(64'h30, 32'd8, 1'b1);
            tx_sizes = '{3, 4, 1};
            send(1'b0);
            cyc(3);
            chk("split_cnt", o_cnt, 2);
            drain("split");

            // Overflow: 5 elements into depth 4, then push+pop while full
            for (int k = 0; k < 5; k++) add_elem(64'h100 * (k + 1), 32'(k + 1), k < 4);
            send(1'b0);
            cyc(3);
            chk("ovf_cnt", o_cnt, 4);
            chk("ovf_flag", o_ovf, 1);
            add_elem(64'hABC0, 32'h55, 1'b1);
            send(1'b0);
            cyc(1);
            pop_chk("full_pushpop");
            chk("full_pushpop_cnt", o_cnt, 4);
            drain("ovf");
            chk("ovf_sticky", o_ovf, 1);

            // Reset mid-list drops everything and clears overflow
            add_elem(64'hA00, 32'h1, 1'b0);
            add_elem(64'hB00, 32'h2, 1'b0);
            tx_words.push_back(32'hC00);
            tx_sizes.push_back(1);
            send(1'b0);
            do_reset();
            for (int i = 0; i < 3; i++) begin
                chk("midrst_no_ld", o_ld, 0);
                cyc(1);
            end
            chk("midrst_cnt", o_cnt, 0);
            chk("midrst_ovf", o_ovf, 0);
            add_elem(64'h900_0000, 32'h44, 1'b1);
            send(1'b0);
            cyc(3);
            chk("midrst_new_cnt", o_cnt, 1);
            drain("midrst");

            // DONE after 6 words: one element kept, partial discarded, one LIST_DONE pulse
            add_elem(64'h500, 32'h10, 1'b1);
            tx_words.push_back(32'hAA);
            tx_words.push_back(32'hBB);
            tx_sizes.push_back(2);
            send(1'b1);
            cyc(1);
            chk("done_ld_n1", o_ld, 0);
            cyc(1);
            chk("done_ld_n2", o_ld, 1);
            chk("done_cnt", o_cnt, 1);
            cyc(1);
            chk("done_ld_n3", o_ld, 0);
            add_elem(64'h600, 32'h20, 1'b1);
            send(1'b0);
            cyc(3);
            chk("done_next_cnt", o_cnt, 2);
            drain("done");

            // ERR with DONE flushes stored and partial elements, no LIST_DONE
            for (int k = 0; k < 3; k++) add_elem(64'h4000 + 64'(k), 32'(k + 7), 1'b0);
            send(1'b0);
            cyc(3);
            chk("err_pre_cnt", o_cnt, 3);
            tx_words = '{32'h700, 32'h7};
            tx_sizes.push_back(2);
            send(1'b0);
            beat('0, 3'd0, 1'b1, 1'b1);
            for (int i = 0; i < 4; i++) begin
                chk("err_no_ld", o_ld, 0);
                cyc(1);
            end
            chk("err_cnt", o_cnt, 0);
            chk("err_rdy", o_rdy, 0);
            add_elem(64'h800_0000, 32'h33, 1'b1);
            send(1'b0);
            cyc(3);
            chk("err_next_cnt", o_cnt, 1);
            drain("err");

            // Zero-length element
            add_elem(64'hC00, 32'h0, !SKIP_ZERO);
            send(1'b0);
            cyc(3);
            chk("zlen_cnt", o_cnt, SKIP_ZERO ? 0 : 1);
            drain("zlen");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
